// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, frame
// constants, error codes and the odd-parity helper.
package ps2_pkg;

  // Transmitter sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Fixed frame bit values on the wire.
  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;

  // Index of the stop bit inside the latched {stop, parity, data} frame.
  localparam logic [3:0] PS2_LAST_BIT_IDX = 4'd9;

  // tx_err_code values.
  localparam logic PS2_ERR_NACK    = 1'b0;
  localparam logic PS2_ERR_TIMEOUT = 1'b1;

  // Odd parity: the parity bit makes the total count of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-flop synchronizers on clock and data, a
// consecutive-sample filter on the clock line, and a one-cycle pulse on each
// filtered clock falling edge. Usable by both the transmit and receive paths.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_level_o,
  output logic data_level_o,
  output logic fall_edge_o
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]       clk_sync_q;
  logic [1:0]       data_sync_q;
  logic             clk_level_q, clk_level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // Bring both asynchronous pads into the clk domain; idle lines are high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the two stages really are two stages.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
    end
  end

  // Accept a clock level change only after FILTER_LEN consecutive differing samples.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    clk_level_d = clk_level_q;
    cnt_d       = '0;
    fall_d      = 1'b0;
    if (clk_sync_q[1] != clk_level_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        clk_level_d = clk_sync_q[1];
        fall_d      = ~clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state and the registered falling-edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_level_q <= 1'b1;
      cnt_q       <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_level_q <= clk_level_d;
      cnt_q       <= cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_level_o  = clk_level_q;
  assign data_level_o = data_sync_q[1];
  assign fall_edge_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Accepts one command byte, inhibits the
// bus, issues the start bit, shifts data/parity/stop on device clock falling
// edges, checks the device ack and reports done or error (NACK / timeout).
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       tx_err_code,
  output logic       tx_active,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  ps2_tx_state_e state_q, state_d;

  logic [9:0]       frame_q, frame_d;      // {stop, parity, data[7:0]}
  logic [3:0]       bit_cnt_q, bit_cnt_d;  // frame bits presented so far
  logic             bit_q, bit_d;          // frame bit currently on the wire
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             err_code_q, err_code_d;

  logic clk_level;
  logic data_level;
  logic fall_edge;
  logic accept;
  logic tmo_hit;
  logic inh_done;
  logic err_pulse;
  logic err_code_now;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk          (ACLK),
    .rst_n        (ARESETN),
    .ps2_clk_i    (ps2_clk_i),
    .ps2_data_i   (ps2_data_i),
    .clk_level_o  (clk_level),
    .data_level_o (data_level),
    .fall_edge_o  (fall_edge)
  );

  assign accept   = tx_valid && (state_q == ST_IDLE);
  assign inh_done = (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1));
  // The cycle after accept sees tmo_cnt_q = 0, so the hit lands TIMEOUT_CYCLES
  // cycles after the accepting cycle.
  assign tmo_hit  = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // State register; reset returns to IDLE, which releases both lines at once.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; timeout overrides any simultaneous line event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (accept) state_d = ST_INHIBIT;
      ST_INHIBIT:   if (inh_done) state_d = ST_START;
      ST_START:     if (fall_edge) state_d = ST_DATA;
      ST_DATA:      if (fall_edge && (bit_cnt_q == PS2_LAST_BIT_IDX)) state_d = ST_ACK;
      ST_ACK:       if (fall_edge) state_d = data_level ? ST_IDLE : ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (clk_level && data_level) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (tmo_hit) state_d = ST_IDLE;
  end

  // Outputs: line drives, status and the done/error pulses of the final cycle.
  always_comb begin
    tx_ready     = (state_q == ST_IDLE);
    tx_active    = (state_q != ST_IDLE);
    ps2_clk_oe   = 1'b0;
    ps2_data_oe  = 1'b0;
    tx_done      = 1'b0;
    err_pulse    = 1'b0;
    err_code_now = PS2_ERR_NACK;
    case (state_q)
      ST_INHIBIT:   ps2_clk_oe  = 1'b1;
      ST_START:     ps2_data_oe = ~PS2_START_BIT;
      ST_DATA:      ps2_data_oe = ~bit_q;
      ST_ACK:       if (fall_edge && data_level) err_pulse = 1'b1;
      ST_WAIT_IDLE: if (clk_level && data_level) tx_done = 1'b1;
      default:      ;
    endcase
    if (tmo_hit) begin
      ps2_clk_oe   = 1'b0;
      ps2_data_oe  = 1'b0;
      tx_done      = 1'b0;
      err_pulse    = 1'b1;
      err_code_now = PS2_ERR_TIMEOUT;
    end
    tx_err      = err_pulse;
    tx_err_code = err_pulse ? err_code_now : err_code_q;
  end

  // Datapath next values: frame latch, bit shifting and the two counters.
  always_comb begin
    frame_d    = frame_q;
    bit_cnt_d  = bit_cnt_q;
    bit_d      = bit_q;
    inh_cnt_d  = inh_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    err_code_d = err_pulse ? err_code_now : err_code_q;
    if (state_q != ST_IDLE) tmo_cnt_d = tmo_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d   = {PS2_STOP_BIT, ps2_odd_parity(tx_data), tx_data};
          bit_cnt_d = '0;
          inh_cnt_d = '0;
          tmo_cnt_d = '0;
        end
      end
      ST_INHIBIT: inh_cnt_d = inh_cnt_q + 1'b1;
      ST_START: begin
        if (fall_edge) begin
          bit_d     = frame_q[0];
          bit_cnt_d = 4'd1;
        end
      end
      ST_DATA: begin
        if (fall_edge) begin
          bit_d     = frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      frame_q    <= '0;
      bit_cnt_q  <= '0;
      bit_q      <= PS2_STOP_BIT;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      err_code_q <= PS2_ERR_NACK;
    end else begin
      frame_q    <= frame_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_q      <= bit_d;
      inh_cnt_q  <= inh_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_code_q <= err_code_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with an open-drain line model and a
// simple PS/2 device that clocks the frame, samples bits and optionally acks.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int TMO  = 2000;
  localparam int FLT  = 4;
  localparam int HALF = 20;  // device clock half period in ACLK cycles

  // Expected wire frames, index 0 first: {stop, odd parity, data, start}.
  localparam logic [10:0] ED_FRAME = {1'b1, 1'b1, 8'hED, 1'b0};
  localparam logic [10:0] FF_FRAME = {1'b1, 1'b1, 8'hFF, 1'b0};
  localparam logic [10:0] X01_FRAME = {1'b1, 1'b0, 8'h01, 1'b0};
  localparam logic [10:0] F0_FRAME = {1'b1, 1'b1, 8'hF0, 1'b0};

  logic       ACLK = 1'b0;
  logic       ARESETN;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, tx_done, tx_err, tx_err_code, tx_active;
  logic       ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low, glitch_low;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_done_cyc = 0;
  int last_accept_cyc = 0;

  logic [10:0] bits;
  logic        started;
  int          d0, e0, d1, n;

  // Open-drain wired-AND of host, device and glitch injector.
  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low | glitch_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLT)
  ) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .tx_err_code (tx_err_code),
    .tx_active   (tx_active),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) cyc <= cyc + 1;

  // Pulse monitor, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (tx_done) begin
      done_cnt      <= done_cnt + 1;
      last_done_cyc <= cyc;
    end
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
    if (tx_valid && tx_ready) last_accept_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(posedge ACLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int k;
    k = 0;
    while (done_cnt == base && k < 200) begin
      cycles(1);
      k++;
    end
  endtask

  // Device: waits for the host start condition, samples the start bit, then
  // gives 10 clocks sampling at the end of each low phase, and an 11th clock
  // during which it optionally pulls data low as the ack.
  task automatic dev_frame(input logic do_ack, input logic do_glitch,
                           output logic [10:0] fr, output logic seen);
    int k;
    fr   = '1;
    seen = 1'b0;
    k    = 0;
    while (!(ps2_clk_i && !ps2_data_i) && k < 1000) begin
      cycles(1);
      k++;
    end
    if (k < 1000) begin
      seen = 1'b1;
      cycles(HALF);
      fr[0] = ps2_data_i;
      for (int i = 1; i <= 10; i++) begin
        dev_clk_low = 1'b1;
        cycles(HALF);
        fr[i] = ps2_data_i;
        dev_clk_low = 1'b0;
        if (do_glitch && i == 3) begin
          cycles(8);
          glitch_low = 1'b1;
          cycles(2);
          glitch_low = 1'b0;
          cycles(HALF - 10);
        end else begin
          cycles(HALF);
        end
      end
      if (do_ack) dev_data_low = 1'b1;
      cycles(5);
      dev_clk_low = 1'b1;
      cycles(HALF);
      dev_clk_low = 1'b0;
      cycles(HALF / 2);
      dev_data_low = 1'b0;
    end
  endtask

  initial begin
    ARESETN      = 1'b0;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    glitch_low   = 1'b0;
    cycles(3);

    // Reset state.
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_active", tx_active, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_err", tx_err, 0);
    check("rst_err_code", tx_err_code, 0);
    ARESETN = 1'b1;
    cycles(5);

    // 0xED acked by the device.
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hED);
    check("ed_active", tx_active, 1);
    check("ed_ready_low", tx_ready, 0);
    dev_frame(1'b1, 1'b0, bits, started);
    check("ed_start_seen", started, 1);
    check("ed_frame", bits, ED_FRAME);
    wait_done(d0);
    check("ed_done_pulses", done_cnt - d0, 1);
    check("ed_no_err", err_cnt - e0, 0);
    cycles(2);
    check("ed_idle_ready", tx_ready, 1);

    // 0xFF then 0x01 back to back; tx_valid held so 0x01 goes on the first free cycle.
    d0       = done_cnt;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    cycles(1);
    tx_data  = 8'h01;
    dev_frame(1'b1, 1'b0, bits, started);
    check("ff_frame", bits, FF_FRAME);
    wait_done(d0);
    check("ff_done_pulses", done_cnt - d0, 1);
    d1 = last_done_cyc;
    cycles(2);
    check("b2b_accept_cycle", last_accept_cyc, d1 + 1);
    tx_valid = 1'b0;
    d0 = done_cnt;
    dev_frame(1'b1, 1'b0, bits, started);
    check("x01_frame", bits, X01_FRAME);
    wait_done(d0);
    check("x01_done_pulses", done_cnt - d0, 1);
    cycles(5);

    // 2-cycle clock glitch during the 0xED frame must not advance the shifter.
    d0 = done_cnt;
    send(8'hED);
    dev_frame(1'b1, 1'b1, bits, started);
    check("glitch_frame", bits, ED_FRAME);
    wait_done(d0);
    check("glitch_done_pulses", done_cnt - d0, 1);
    cycles(5);

    // Device never clocks: timeout TMO cycles after the accepting cycle.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    n = 1;
    while (!tx_err && n < 3000) begin
      cycles(1);
      n++;
    end
    check("tmo_latency", n, TMO);
    check("tmo_code", tx_err_code, 1);
    check("tmo_clk_oe", ps2_clk_oe, 0);
    check("tmo_data_oe", ps2_data_oe, 0);
    check("tmo_no_done", tx_done, 0);
    cycles(1);
    check("tmo_ready_after", tx_ready, 1);
    check("tmo_err_single", tx_err, 0);
    check("tmo_code_held", tx_err_code, 1);
    cycles(5);

    // Device withholds the ack: NACK error, lines free and ready next cycle.
    d0 = done_cnt;
    send(8'hF0);
    fork
      dev_frame(1'b0, 1'b0, bits, started);
      begin : nack_mon
        int  k;
        logic got;
        k   = 0;
        got = 1'b0;
        while (!got && k < 2000) begin
          @(negedge ACLK);
          if (tx_err) got = 1'b1;
          else k++;
        end
        check("nack_seen", got, 1);
        check("nack_code", tx_err_code, 0);
        check("nack_no_done", tx_done, 0);
        @(negedge ACLK);
        check("nack_ready_after", tx_ready, 1);
        check("nack_clk_oe", ps2_clk_oe, 0);
        check("nack_data_oe", ps2_data_oe, 0);
        check("nack_code_held", tx_err_code, 0);
      end
    join
    check("f0_frame", bits, F0_FRAME);
    check("nack_no_done_total", done_cnt - d0, 0);
    cycles(5);

    // Asynchronous reset while data bit 4 (a 0 for 0xED) is being driven.
    send(8'hED);
    n = 0;
    while (!(ps2_clk_i && !ps2_data_i) && n < 1000) begin
      cycles(1);
      n++;
    end
    check("rst_mid_start_seen", n < 1000, 1);
    cycles(HALF);
    for (int k = 1; k <= 5; k++) begin
      dev_clk_low = 1'b1;
      cycles(HALF);
      if (k < 5) begin
        dev_clk_low = 1'b0;
        cycles(HALF);
      end
    end
    check("rst_mid_pre_data_oe", ps2_data_oe, 1);
    check("rst_mid_pre_active", tx_active, 1);
    #2;
    ARESETN = 1'b0;
    #1;
    check("rst_mid_clk_oe", ps2_clk_oe, 0);
    check("rst_mid_data_oe", ps2_data_oe, 0);
    check("rst_mid_active", tx_active, 0);
    dev_clk_low = 1'b0;
    cycles(3);
    ARESETN = 1'b1;
    cycles(1);
    check("rst_mid_ready_after", tx_ready, 1);
    check("rst_mid_data_oe_after", ps2_data_oe, 0);

    check("done_err_exclusive", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
